// File: rtl/tvip_axi_burst_address_generator_if.sv
// Burst request / per-beat handshake bundle for the AXI burst address generator.
// master: issues burst requests, consumes beats. slave: the generator itself.
interface tvip_axi_burst_address_generator_if #(
    parameter int ID_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 64,
    parameter int DATA_WIDTH    = 32
);
    localparam int BYTE_LANES = DATA_WIDTH / 8;

    logic                     request_valid;
    logic                     request_ready;
    logic [ID_WIDTH-1:0]      request_id;
    logic [ADDRESS_WIDTH-1:0] request_address;
    logic [7:0]               request_burst_length;
    logic [2:0]               request_burst_size;
    logic [1:0]               request_burst_type;

    logic                     beat_valid;
    logic                     beat_ready;
    logic [ID_WIDTH-1:0]      beat_id;
    logic [ADDRESS_WIDTH-1:0] beat_address;
    logic [BYTE_LANES-1:0]    beat_strobe;
    logic [7:0]               beat_index;
    logic                     beat_last;

    modport master (
        output request_valid, request_id, request_address,
        output request_burst_length, request_burst_size, request_burst_type,
        input  request_ready,
        input  beat_valid, beat_id, beat_address, beat_strobe,
        input  beat_index, beat_last,
        output beat_ready
    );

    modport slave (
        input  request_valid, request_id, request_address,
        input  request_burst_length, request_burst_size, request_burst_type,
        output request_ready,
        output beat_valid, beat_id, beat_address, beat_strobe,
        output beat_index, beat_last,
        input  beat_ready
    );
endinterface

// File: rtl/tvip_axi_burst_address_generator.sv
// Expands an AXI burst request (FIXED/INCR/WRAP) into per-beat address,
// strobe, index and last. Ports: aclk, areset (sync, active-high), bus (slave).
module tvip_axi_burst_address_generator #(
    parameter int ID_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 64,
    parameter int DATA_WIDTH    = 32
) (
    input  logic aclk,
    input  logic areset,
    tvip_axi_burst_address_generator_if.slave bus
);
    localparam int BYTE_LANES = DATA_WIDTH / 8;
    localparam int LANE_LOG   = $clog2(BYTE_LANES);

    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {KIND_FIXED, KIND_INCR, KIND_WRAP} kind_t;

    localparam logic [2:0] MAX_SIZE  = 3'(LANE_LOG);
    localparam addr_t      LANE_MASK = addr_t'(BYTE_LANES - 1);

    state_t              state;
    state_t              state_next;
    logic [ID_WIDTH-1:0] id_q;
    addr_t               addr_q;
    addr_t               wrap_mask_q;
    logic [7:0]          length_q;
    logic [7:0]          index_q;
    logic [2:0]          size_q;
    kind_t               kind_q;

    logic       busy;
    logic       is_last;
    logic       beat_fire;
    logic       request_fire;
    logic [2:0] size_c;
    kind_t      kind_c;
    addr_t      wrap_mask_c;
    addr_t      bytes_q;
    addr_t      aligned;
    addr_t      incremented;
    addr_t      next_address;
    addr_t      lane_lo;
    addr_t      lane_hi;

    assign busy         = (state == BUSY);
    assign is_last      = (index_q == length_q);
    assign beat_fire    = busy & bus.beat_ready;
    assign request_fire = bus.request_valid & bus.request_ready & ~areset;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (request_fire) state_next = BUSY;
            BUSY:    if (beat_fire && is_last && !request_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new request can ride on the final beat handshake for zero-bubble bursts.
    always_comb begin
        bus.beat_valid    = busy;
        bus.beat_last     = busy & is_last;
        bus.request_ready = ~busy | (beat_fire & is_last);
    end

    // Request decode: clamp size to the bus, demote odd WRAP lengths to INCR.
    always_comb begin
        size_c = (bus.request_burst_size > MAX_SIZE) ? MAX_SIZE
                                                     : bus.request_burst_size;
        wrap_mask_c = ((addr_t'(bus.request_burst_length) + addr_t'(1)) << size_c)
                    - addr_t'(1);
        unique case (bus.request_burst_type)
            2'b00: kind_c = KIND_FIXED;
            2'b10: begin
                unique case (bus.request_burst_length)
                    8'd1, 8'd3, 8'd7, 8'd15: kind_c = KIND_WRAP;
                    default:                 kind_c = KIND_INCR;
                endcase
            end
            default: kind_c = KIND_INCR;
        endcase
    end

    // Wrap keeps the span base bits and lets only the offset bits advance.
    always_comb begin
        bytes_q     = addr_t'(1) << size_q;
        aligned     = addr_q & ~(bytes_q - addr_t'(1));
        incremented = aligned + bytes_q;
        unique case (kind_q)
            KIND_FIXED: next_address = addr_q;
            KIND_WRAP:  next_address = (addr_q & ~wrap_mask_q)
                                     | (incremented & wrap_mask_q);
            default:    next_address = incremented;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            id_q        <= '0;
            addr_q      <= '0;
            wrap_mask_q <= '0;
            length_q    <= '0;
            index_q     <= '0;
            size_q      <= '0;
            kind_q      <= KIND_FIXED;
        end else if (request_fire) begin
            id_q        <= bus.request_id;
            addr_q      <= bus.request_address;
            wrap_mask_q <= wrap_mask_c;
            length_q    <= bus.request_burst_length;
            index_q     <= '0;
            size_q      <= size_c;
            kind_q      <= kind_c;
        end else if (beat_fire && !is_last) begin
            index_q <= index_q + 8'd1;
            addr_q  <= next_address;
        end
    end

    // Lanes from the byte offset up to the end of the size-aligned container.
    always_comb begin
        lane_lo = addr_q & LANE_MASK;
        lane_hi = (aligned & LANE_MASK) + bytes_q - addr_t'(1);
        for (int i = 0; i < BYTE_LANES; i++) begin
            bus.beat_strobe[i] = busy
                               && (addr_t'(i) >= lane_lo)
                               && (addr_t'(i) <= lane_hi);
        end
    end

    assign bus.beat_id      = id_q;
    assign bus.beat_address = addr_q;
    assign bus.beat_index   = index_q;
endmodule

// File: doc/tvip_axi_burst_address_generator.md
TVIP_AXI_BURST_ADDRESS_GENERATOR -- requirements
Module: tvip_axi_burst_address_generator

Interface
REQ-001 Parameter ID_WIDTH, default 8: width of the request and beat ID.
REQ-002 Parameter ADDRESS_WIDTH, default 64: width of the request and beat address.
REQ-003 Parameter DATA_WIDTH, default 32: data bus width in bits; BYTE_LANES = DATA_WIDTH/8; legal values are 8 to 1024, powers of 2.
REQ-004 Port aclk, input, 1: single clock; all logic is on the rising edge.
REQ-005 Port areset, input, 1: reset, synchronous and active-high.
REQ-006 Port request_valid / request_ready, input / output, 1 each: burst request handshake.
REQ-007 Port request_id, input, ID_WIDTH: transaction ID.
REQ-008 Port request_address, input, ADDRESS_WIDTH: start address, may be unaligned.
REQ-009 Port request_burst_length, input, 8: packed length; number of beats = value + 1.
REQ-010 Port request_burst_size, input, 3: encoded size; bytes per beat = 2^value.
REQ-011 Port request_burst_type, input, 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 Port beat_valid / beat_ready, output / input, 1 each: per-beat handshake.
REQ-013 Port beat_id, output, ID_WIDTH: ID of the owning burst.
REQ-014 Port beat_address, output, ADDRESS_WIDTH: address of the current beat.
REQ-015 Port beat_strobe, output, BYTE_LANES: byte lanes active for the current beat.
REQ-016 Port beat_index, output, 8: zero-based index of the current beat.
REQ-017 Port beat_last, output, 1: asserted on the final beat of the burst.

Function
REQ-018 The block shall use two states, IDLE and BUSY. IDLE moves to BUSY on a request handshake. BUSY moves to IDLE on a handshake of the last beat, unless a new request is accepted in the same cycle.
REQ-019 request_ready shall equal (state==IDLE) | (beat_valid & beat_ready & beat_last). This gives zero-bubble back-to-back bursts.
REQ-020 When a request is accepted at edge T, beat 0 shall be valid from T+1. Throughput shall be one beat per cycle while beat_ready=1.
REQ-021 While beat_valid=1 and beat_ready=0, every beat_* output shall hold stable.
REQ-022 Beat 0 address shall equal request_address for every burst type.
REQ-023 FIXED bursts: every beat address shall equal request_address.
REQ-024 INCR bursts: beat n address shall equal align(request_address, size) + n*size for n≥1, modulo 2^ADDRESS_WIDTH. There is no 4KB boundary check.
REQ-025 WRAP bursts:
- span = size*beats; lower = floor(addr/span)*span.
- Each next address is current aligned address + size; when it reaches lower+span it becomes lower.
REQ-026 WRAP with a beat count other than 2, 4, 8 or 16 shall be treated as INCR.
REQ-027 Reserved burst type 11 shall be treated as INCR.
REQ-028 A burst size greater than BYTE_LANES bytes shall be clamped to BYTE_LANES bytes.
REQ-029 beat_strobe shall set lanes from (beat_address mod BYTE_LANES) up to the end of the size-aligned container holding beat_address. Every other lane shall be 0.
REQ-030 beat_last shall be 1 exactly when beat_index equals request_burst_length. For length 0, beat 0 is last.
REQ-031 Request fields shall be captured at acceptance. Later changes on the request_* inputs shall not affect an in-flight burst.
REQ-032 request_valid while busy (and not on the last-beat handshake) shall be back-pressured: request_ready=0.

Reset
REQ-033 While areset=1 at a rising edge, the state shall be IDLE next cycle.
REQ-034 Reset values: beat_valid=0, beat_last=0, beat_index=0, beat_address=0, beat_strobe=0, beat_id=0, request_ready=1.
REQ-035 Reset during BUSY shall abandon the burst with no further beats. No request shall be accepted in a cycle where areset=1.

Verification
REQ-036 INCR, DATA_WIDTH=32, addr 0x1002, len 3, size 2 (4 bytes) -> addresses 0x1002, 0x1004, 0x1008, 0x100C; strobes 1100, 1111, 1111, 1111; last on beat 3.
REQ-037 WRAP, addr 0x0034, len 3, size 2 -> addresses 0x34, 0x38, 0x3C, 0x30; last on beat 3.
REQ-038 FIXED, addr 0x2001, len 2, size 0 (1 byte) -> three beats at 0x2001, strobe 0010 each.
REQ-039 Two INCR length-0 requests held valid back-to-back, beat_ready=1 -> one beat per cycle with no idle cycle; request_ready=1 on each last-beat cycle.
REQ-040 beat_ready=0 for 3 cycles mid-burst -> outputs stay stable; the burst resumes with no lost or duplicated beat.
REQ-041 areset=1 during beat 2 of a length-7 INCR burst -> beat_valid=0 and request_ready=1 on the next cycle; a following request starts at its own beat 0.
